// File: rtl/bubble_sort_pkg.sv
// Shared state encoding, widths and the Moore output decode for the
// exchange-sort control FSM (bubble_sort_controller).
package bubble_sort_pkg;

   localparam int IDX_W = 5;   // memory index width (32 entries)
   localparam int CNT_W = 6;   // counter width, bit[IDX_W] is the carry-out

   localparam int RD_LAT_COMB = 0;
   localparam int RD_LAT_REG  = 1;

   typedef enum logic [3:0] {
      IDLE, INIT, OUTER, LD_J, INC_J, CHK_J,
      RD_I_WAIT, RD_I, RD_J_WAIT, RD_J,
      CMP, WR_I, WR_J, NEXT_I, DONE
   } state_t;

   typedef struct packed {
      logic s0;
      logic s1;
      logic reg1_ld;
      logic reg2_ld;
      logic c1_inc;
      logic c1_clr;
      logic c1_ld;
      logic c2_inc;
      logic c2_clr;
      logic c2_ld;
      logic rd;
      logic wr;
      logic busy;
      logic done;
   } ctrl_t;

   // The *_WAIT states only exist on the registered-read path; they hold the
   // address and read strobe while Read_DATA settles, without loading.
   function automatic ctrl_t decode(input state_t s);
      ctrl_t c;
      c      = '0;
      c.busy = (s != IDLE);
      case (s)
         INIT:      c.c1_clr = 1'b1;
         LD_J:      c.c2_ld  = 1'b1;
         INC_J:     c.c2_inc = 1'b1;
         RD_I_WAIT: c.rd     = 1'b1;
         RD_I:      begin c.rd = 1'b1; c.reg1_ld = 1'b1; end
         RD_J_WAIT: begin c.s0 = 1'b1; c.rd = 1'b1; end
         RD_J:      begin c.s0 = 1'b1; c.rd = 1'b1; c.reg2_ld = 1'b1; end
         WR_I:      begin c.s1 = 1'b1; c.wr = 1'b1; end
         WR_J:      begin c.s0 = 1'b1; c.wr = 1'b1; end
         NEXT_I:    c.c1_inc = 1'b1;
         DONE:      c.done   = 1'b1;
         default:   ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/bubble_sort_controller.sv
// Control FSM sequencing the exchange-sort datapath over a 32x8 memory.
// Optional macro SORT_DESC_EN selects descending order (swap on gt).
module bubble_sort_controller
   import bubble_sort_pkg::*;
#(
   parameter int RD_LATENCY = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic CO1,
   input  logic CO2,
   input  logic lt,
   input  logic gt,
   output logic S0,
   output logic S1,
   output logic Reg1_ld,
   output logic Reg2_ld,
   output logic C1_inc,
   output logic C1_clr,
   output logic C1_ld,
   output logic C2_inc,
   output logic C2_clr,
   output logic C2_ld,
   output logic rd,
   output logic wr,
   output logic busy,
   output logic done
);

   if (RD_LATENCY != RD_LAT_COMB && RD_LATENCY != RD_LAT_REG) begin : g_bad_latency
      $error("bubble_sort_controller: RD_LATENCY must be 0 or 1");
   end

   state_t state;
   state_t state_nxt;
   ctrl_t  ctrl_q;
   logic   swap;

`ifdef SORT_DESC_EN
   logic unused_lt;
   assign unused_lt = lt;
   assign swap      = gt;
`else
   logic unused_gt;
   assign unused_gt = gt;
   assign swap      = lt;   // strict compare: equal keys never move
`endif

   function automatic state_t next_state(input state_t s, input logic go,
                                         input logic co1_i, input logic co2_i,
                                         input logic swap_i);
      state_t n;
      n = s;
      case (s)
         IDLE:      if (go) n = INIT;
         INIT:      n = OUTER;
         OUTER:     n = co1_i ? DONE : LD_J;
         LD_J:      n = INC_J;
         INC_J:     n = CHK_J;
         CHK_J:     n = co2_i ? NEXT_I : ((RD_LATENCY == RD_LAT_REG) ? RD_I_WAIT : RD_I);
         RD_I_WAIT: n = RD_I;
         RD_I:      n = (RD_LATENCY == RD_LAT_REG) ? RD_J_WAIT : RD_J;
         RD_J_WAIT: n = RD_J;
         RD_J:      n = CMP;
         CMP:       n = swap_i ? WR_I : INC_J;
         WR_I:      n = WR_J;
         WR_J:      n = INC_J;
         NEXT_I:    n = OUTER;
         DONE:      n = IDLE;
         default:   n = IDLE;
      endcase
      return n;
   endfunction

   assign state_nxt = next_state(state, start, CO1, CO2, swap);

   // NOTE: outputs are decoded from the next state and registered alongside
   // it, so they are glitch-free yet still a pure function of the current state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ctrl_q <= '0;
      end else begin
         state  <= state_nxt;
         ctrl_q <= decode(state_nxt);
      end
   end

   assign S0      = ctrl_q.s0;
   assign S1      = ctrl_q.s1;
   assign Reg1_ld = ctrl_q.reg1_ld;
   assign Reg2_ld = ctrl_q.reg2_ld;
   assign C1_inc  = ctrl_q.c1_inc;
   assign C1_clr  = ctrl_q.c1_clr;
   assign C1_ld   = ctrl_q.c1_ld;
   assign C2_inc  = ctrl_q.c2_inc;
   assign C2_clr  = ctrl_q.c2_clr;
   assign C2_ld   = ctrl_q.c2_ld;
   assign rd      = ctrl_q.rd;
   assign wr      = ctrl_q.wr;
   assign busy    = ctrl_q.busy;
   assign done    = ctrl_q.done;

endmodule
